// File: rtl/microps_ldm_stm_sequencer_if.sv
// Decode/execute handshake bundle for the LDM/STM micro-op sequencer.
// The slave modport is the sequencer; the master modport is decode/execute.
interface microps_ldm_stm_sequencer_if #(
  parameter int OFFW = 8
);
  logic            StartD;
  logic [31:0]     InstrD;
  logic            AdvanceD;
  logic            BusyD;
  logic            uOpValid;
  logic [3:0]      uOpRd;
  logic [OFFW-1:0] uOpOffset;
  logic            uOpLoad;
  logic            uOpFirst;
  logic            uOpLast;
  logic            uOpWriteback;
  logic [OFFW-1:0] WbOffset;
  logic            PcLoadFlush;

  modport slave (
    input  StartD, InstrD, AdvanceD,
    output BusyD, uOpValid, uOpRd, uOpOffset, uOpLoad, uOpFirst, uOpLast,
           uOpWriteback, WbOffset, PcLoadFlush
  );

  modport master (
    output StartD, InstrD, AdvanceD,
    input  BusyD, uOpValid, uOpRd, uOpOffset, uOpLoad, uOpFirst, uOpLast,
           uOpWriteback, WbOffset, PcLoadFlush
  );
endinterface

// File: rtl/microps_ldm_stm_sequencer.sv
// Expands one LDM/STM into single-register micro-ops, lowest register first.
// Optional MICROPS_PC_FLUSH_EN: flag LDM-to-PC on the last beat and hold BusyD one extra cycle.
module microps_ldm_stm_sequencer #(
  parameter int REGS = 16,
  parameter int OFFW = 8
) (
  input  logic clk,
  input  logic reset,
  microps_ldm_stm_sequencer_if.slave bus
);

  localparam int CNTW = $clog2(REGS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic [CNTW-1:0] popcnt(input logic [REGS-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < REGS; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest(input logic [REGS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = REGS - 1; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [REGS-1:0] r_list, w_list_nxt;
  logic [CNTW-1:0] r_k, w_k_nxt;
  logic [OFFW-1:0] r_base, w_base_nxt;
  logic [OFFW-1:0] r_wboff, w_wboff_nxt;
  logic            r_w, w_w_nxt;
  logic            r_l, w_l_nxt;

  logic            r_valid, r_first, r_last, r_wb, r_load, r_busy, r_flush;
  logic [3:0]      r_rd;
  logic [OFFW-1:0] r_off, r_wbo_out;

  logic            w_valid_nxt, w_first_nxt, w_last_nxt, w_wb_nxt, w_load_nxt;
  logic            w_busy_nxt, w_flush_nxt, w_flush_go;
  logic [3:0]      w_rd_nxt;
  logic [OFFW-1:0] w_off_nxt, w_wbo_nxt;
  logic [CNTW-1:0] w_n;
  logic [OFFW-1:0] w_n4;

  assign w_n  = popcnt(bus.InstrD[REGS-1:0]);
  assign w_n4 = OFFW'({w_n, 2'b00});

`ifdef MICROPS_PC_FLUSH_EN
  assign w_flush_go = r_flush;
`else
  assign w_flush_go = 1'b0;
`endif

  // Next-state: latch the instruction in IDLE, retire one register per accepted beat
  always_comb begin
    w_state_nxt = r_state;
    w_list_nxt  = r_list;
    w_k_nxt     = r_k;
    w_base_nxt  = r_base;
    w_wboff_nxt = r_wboff;
    w_w_nxt     = r_w;
    w_l_nxt     = r_l;
    case (r_state)
      S_IDLE: begin
        if (bus.StartD && (w_n != '0)) begin
          w_state_nxt = S_RUN;
          w_list_nxt  = bus.InstrD[REGS-1:0];
          w_k_nxt     = '0;
          w_w_nxt     = bus.InstrD[21];
          w_l_nxt     = bus.InstrD[20];
          w_wboff_nxt = bus.InstrD[23] ? w_n4 : (OFFW'(0) - w_n4);
          // Base-relative offset of the lowest register; later beats add 4k
          case ({bus.InstrD[24], bus.InstrD[23]})
            2'b01:   w_base_nxt = '0;
            2'b11:   w_base_nxt = OFFW'(4);
            2'b00:   w_base_nxt = OFFW'(4) - w_n4;
            2'b10:   w_base_nxt = OFFW'(0) - w_n4;
            default: w_base_nxt = '0;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.AdvanceD) begin
          w_k_nxt = r_k + CNTW'(1);
          if (r_last) begin
            w_list_nxt  = '0;
            w_state_nxt = w_flush_go ? S_FLUSH : S_IDLE;
          end else begin
            w_list_nxt  = r_list & ~(REGS'(1) << r_rd);
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from next-state so every output comes straight from a flop
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_rd_nxt    = w_valid_nxt ? lowest(w_list_nxt) : 4'd0;
    w_off_nxt   = w_valid_nxt ? (w_base_nxt + OFFW'({w_k_nxt, 2'b00})) : '0;
    w_first_nxt = w_valid_nxt && (w_k_nxt == '0);
    w_last_nxt  = w_valid_nxt && (popcnt(w_list_nxt) == CNTW'(1));
    w_wb_nxt    = w_last_nxt && w_w_nxt;
    w_load_nxt  = w_valid_nxt && w_l_nxt;
    w_wbo_nxt   = w_busy_nxt ? w_wboff_nxt : '0;
`ifdef MICROPS_PC_FLUSH_EN
    w_flush_nxt = w_last_nxt && w_l_nxt && (w_rd_nxt == 4'd15);
`else
    w_flush_nxt = 1'b0;
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_list    <= '0;
      r_k       <= '0;
      r_base    <= '0;
      r_wboff   <= '0;
      r_w       <= 1'b0;
      r_l       <= 1'b0;
      r_valid   <= 1'b0;
      r_rd      <= 4'd0;
      r_off     <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_wb      <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_wbo_out <= '0;
      r_flush   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_list    <= w_list_nxt;
      r_k       <= w_k_nxt;
      r_base    <= w_base_nxt;
      r_wboff   <= w_wboff_nxt;
      r_w       <= w_w_nxt;
      r_l       <= w_l_nxt;
      r_valid   <= w_valid_nxt;
      r_rd      <= w_rd_nxt;
      r_off     <= w_off_nxt;
      r_first   <= w_first_nxt;
      r_last    <= w_last_nxt;
      r_wb      <= w_wb_nxt;
      r_load    <= w_load_nxt;
      r_busy    <= w_busy_nxt;
      r_wbo_out <= w_wbo_nxt;
      r_flush   <= w_flush_nxt;
    end
  end

  assign bus.BusyD        = r_busy;
  assign bus.uOpValid     = r_valid;
  assign bus.uOpRd        = r_rd;
  assign bus.uOpOffset    = r_off;
  assign bus.uOpLoad      = r_load;
  assign bus.uOpFirst     = r_first;
  assign bus.uOpLast      = r_last;
  assign bus.uOpWriteback = r_wb;
  assign bus.WbOffset     = r_wbo_out;
  assign bus.PcLoadFlush  = r_flush;

endmodule

// File: tb/tb_microps_ldm_stm_sequencer.sv
// Directed bench for the LDM/STM sequencer; packed observation vector
// {valid, rd, offset, first, last, wb, load, busy, wboffset, pcflush}.
module tb_microps_ldm_stm_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

`ifdef MICROPS_PC_FLUSH_EN
  localparam logic FL_EN = 1'b1;
`else
  localparam logic FL_EN = 1'b0;
`endif

  microps_ldm_stm_sequencer_if #(.OFFW(8)) bus ();

  microps_ldm_stm_sequencer #(.REGS(16), .OFFW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [26:0] obs;
  assign obs = {bus.uOpValid, bus.uOpRd, bus.uOpOffset, bus.uOpFirst, bus.uOpLast,
                bus.uOpWriteback, bus.uOpLoad, bus.BusyD, bus.WbOffset, bus.PcLoadFlush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h00B0_0015;
    bus.AdvanceD = 1'b1;
    cyc();
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, 27'd0);
    end
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    reset = 1'b0;
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_ldmia();
    logic [26:0] e;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h00B0_0015;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    for (int k = 0; k < 3; k++) begin
      e = {1'b1, 4'(2 * k), 8'(4 * k), k == 0, k == 2, k == 2, 1'b1, 1'b1, 8'd12, 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ldmia beat%0d got=%h exp=%h", k, obs, e);
      end
      cyc();
    end
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL ldmia_done got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_stmdb();
    logic [26:0] e;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h0120_4003;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    for (int k = 0; k < 3; k++) begin
      e = {1'b1, (k == 2) ? 4'd14 : 4'(k), 8'(-12 + 4 * k), k == 0, k == 2, k == 2,
           1'b0, 1'b1, 8'hF4, 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stmdb beat%0d got=%h exp=%h", k, obs, e);
      end
      cyc();
    end
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL stmdb_done got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_ldmib_full();
    logic [26:0] e;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h0190_FFFF;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    for (int k = 0; k < 16; k++) begin
      e = {1'b1, 4'(k), 8'(4 * (k + 1)), k == 0, k == 15, 1'b0, 1'b1, 1'b1, 8'h40,
           FL_EN && (k == 15)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ldmib beat%0d got=%h exp=%h", k, obs, e);
      end
      cyc();
    end
    e = FL_EN ? {1'b0, 4'd0, 8'd0, 4'b0000, 1'b1, 8'h40, 1'b0} : 27'd0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ldmib_after got=%h exp=%h", obs, e);
    end
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL ldmib_idle got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_stmdb_full();
    logic [26:0] e;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h0100_FFFF;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    for (int k = 0; k < 16; k++) begin
      e = {1'b1, 4'(k), 8'(-64 + 4 * k), k == 0, k == 15, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stmdb16 beat%0d got=%h exp=%h", k, obs, e);
      end
      cyc();
    end
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL stmdb16_done got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_stall_single();
    logic [26:0] e;
    e = {1'b1, 4'd8, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0};
    bus.StartD = 1'b1;
    bus.InstrD = 32'h0010_0100;
    bus.AdvanceD = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall hold%0d got=%h exp=%h", i, obs, e);
      end
      // A new StartD while busy (and on the accepting edge) must be ignored
      bus.StartD = (i >= 1);
      bus.InstrD = (i >= 1) ? 32'h00B0_0003 : 32'd0;
      bus.AdvanceD = (i == 2);
      cyc();
    end
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL stall_done got=%h exp=%h", obs, 27'd0);
    end
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL stall_ignored_start got=%h exp=%h", obs, 27'd0);
    end
  endtask

  task automatic test_empty();
    bus.StartD = 1'b1;
    bus.InstrD = 32'h00B0_0000;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== 27'd0) begin
        errors++;
        $display("FAIL empty cyc%0d got=%h exp=%h", i, obs, 27'd0);
      end
      cyc();
    end
  endtask

  task automatic test_midreset();
    logic [26:0] e;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h00B0_000F;
    bus.AdvanceD = 1'b1;
    cyc();
    bus.StartD = 1'b0;
    e = {1'b1, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd16, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset beat0 got=%h exp=%h", obs, e);
    end
    cyc();
    e = {1'b1, 4'd1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd16, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset beat1 got=%h exp=%h", obs, e);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL midreset cleared got=%h exp=%h", obs, 27'd0);
    end
    reset = 1'b0;
    bus.StartD = 1'b1;
    bus.InstrD = 32'h0090_0030;
    cyc();
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    e = {1'b1, 4'd4, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd8, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset fresh0 got=%h exp=%h", obs, e);
    end
    cyc();
    e = {1'b1, 4'd5, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd8, 1'b0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset fresh1 got=%h exp=%h", obs, e);
    end
    cyc();
    checks++;
    if (obs !== 27'd0) begin
      errors++;
      $display("FAIL midreset_done got=%h exp=%h", obs, 27'd0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.StartD = 1'b0;
    bus.InstrD = 32'd0;
    bus.AdvanceD = 1'b0;
    cyc();
    test_reset();
    test_ldmia();
    test_stmdb();
    test_ldmib_full();
    test_stmdb_full();
    test_stall_single();
    test_empty();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
